l2_instruction_responder: RTL and testbench

- L2-side responder for the instruction cache miss interface.
- Accepts line-fill requests on the address channel (valid/ready) and queues them in a small request FIFO.
- For each request, reads the line as WORD_WIDTH-bit words from a synchronous backing RAM and assembles them into one L2_BUS_WIDTH-bit line.
- Returns the line on the data channel (valid/ready). Sits between the instruction cache and the backing memory.

---
 rtl/l2_instruction_responder.sv | 219 +++++++++++++++++++++
 tb/tb_l2_instruction_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_instruction_responder.sv
// l2_instruction_responder
//   L2-side responder for instruction-cache line fills. Line requests are
//   queued in a small request FIFO. Each line is read from a synchronous
//   backing RAM one word at a time, assembled into one line, and returned
//   on the data channel.
//
// Ports
//   CLK, RST_N                   clock; synchronous active-low reset
//   ADDRESS_TO_L2_VALID_INS      in   request valid
//   ADDRESS_TO_L2_READY_INS      out  request ready (FIFO not full)
//   ADDRESS_TO_L2_INS            in   requested word address
//   DATA_FROM_L2_VALID_INS       out  line valid
//   DATA_FROM_L2_READY_INS       in   cache accepts line
//   DATA_FROM_L2_INS             out  line data, word k in lane k
//   MEM_READ_EN                  out  backing-RAM read strobe
//   MEM_ADDRESS                  out  backing-RAM word address
//   MEM_DATA                     in   read data, one cycle after MEM_READ_EN
//
// Build option
//   L2_INS_CRITICAL_WORD_FIRST_EN : when defined, the requested word is
//   fetched first and the fetch order wraps within the line. Line contents
//   and latency are unchanged.
//
// State table
//   S_IDLE    | no line in progress; pops the FIFO when it holds a request
//   S_FETCH   | issuing BEATS reads, then capturing the last returned word
//   S_RESPOND | line valid on the data channel, held until the handshake

module l2_instruction_responder #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int L2_BUS_WIDTH   = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int REQ_FIFO_DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
  output logic                     MEM_READ_EN,
  output logic [ADDRESS_WIDTH-3:0] MEM_ADDRESS,
  input  logic [WORD_WIDTH-1:0]    MEM_DATA
);

  localparam int WADDR_W     = ADDRESS_WIDTH - 2;
  localparam int BEATS       = L2_BUS_WIDTH / WORD_WIDTH;
  localparam int OFFSET_BITS = $clog2(BEATS);
  localparam int PTR_W       = $clog2(REQ_FIFO_DEPTH);

  localparam logic [WADDR_W-1:0]     OFFSET_MASK = WADDR_W'(BEATS - 1);
  localparam logic [PTR_W:0]         PTR_ONE     = 1;
  localparam logic [OFFSET_BITS:0]   CNT_ONE     = 1;
  localparam logic [OFFSET_BITS-1:0] LAST_IDX    = OFFSET_BITS'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------
  // Request FIFO (pointers carry one extra wrap bit for full/empty)
  // ---------------------------------------------------------------------
  logic [WADDR_W-1:0] r_fifo_mem [REQ_FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [WADDR_W-1:0] w_push_word;
  logic [WADDR_W-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head  = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];

`ifdef L2_INS_CRITICAL_WORD_FIRST_EN
  // Keep the offset bits: they select the first word fetched.
  assign w_push_word = ADDRESS_TO_L2_INS;
`else
  assign w_push_word = ADDRESS_TO_L2_INS & ~OFFSET_MASK;
`endif

  assign w_push = ADDRESS_TO_L2_VALID_INS && !w_full;
  assign w_pop  = !w_empty &&
                  ((r_state == S_IDLE) ||
                   ((r_state == S_RESPOND) && DATA_FROM_L2_READY_INS));

  assign ADDRESS_TO_L2_READY_INS = !w_full;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_word;
        r_wr_ptr                        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Fetch datapath
  // ---------------------------------------------------------------------
  logic [WADDR_W-1:0]      r_base;
  logic [OFFSET_BITS:0]    r_issue_cnt;   // reaches BEATS when all reads issued
  logic                    r_rd_pending;  // a read was issued last cycle
  logic [OFFSET_BITS-1:0]  r_pend_idx;    // issue index of that read
  logic [L2_BUS_WIDTH-1:0] r_line;
  logic                    w_issue_active;
  logic                    w_last_capture;
  logic [OFFSET_BITS-1:0]  w_issue_beat;
  logic [OFFSET_BITS-1:0]  w_capture_lane;

  assign w_issue_active = (r_state == S_FETCH) && !r_issue_cnt[OFFSET_BITS];
  assign w_last_capture = r_rd_pending && (r_pend_idx == LAST_IDX);

`ifdef L2_INS_CRITICAL_WORD_FIRST_EN
  logic [OFFSET_BITS-1:0] r_offset;

  // Offset addition wraps within the line by width truncation.
  assign w_issue_beat   = r_offset + r_issue_cnt[OFFSET_BITS-1:0];
  assign w_capture_lane = r_offset + r_pend_idx;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_offset <= '0;
    end else if (w_pop) begin
      r_offset <= w_head[OFFSET_BITS-1:0];
    end
  end
`else
  assign w_issue_beat   = r_issue_cnt[OFFSET_BITS-1:0];
  assign w_capture_lane = r_pend_idx;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_base       <= '0;
      r_issue_cnt  <= '0;
      r_rd_pending <= 1'b0;
      r_pend_idx   <= '0;
      r_line       <= '0;
    end else begin
      r_rd_pending <= w_issue_active;
      r_pend_idx   <= r_issue_cnt[OFFSET_BITS-1:0];
      if (w_pop) begin
        r_base      <= w_head & ~OFFSET_MASK;
        r_issue_cnt <= '0;
      end else if (w_issue_active) begin
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
      if (r_rd_pending) begin
        r_line[WORD_WIDTH*w_capture_lane +: WORD_WIDTH] <= MEM_DATA;
      end
    end
  end

  assign DATA_FROM_L2_INS = r_line;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_last_capture) w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        if (DATA_FROM_L2_READY_INS) w_state_nxt = w_empty ? S_IDLE : S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    DATA_FROM_L2_VALID_INS = 1'b0;
    MEM_READ_EN            = 1'b0;
    MEM_ADDRESS            = '0;
    case (r_state)
      S_FETCH: begin
        if (w_issue_active) begin
          MEM_READ_EN = 1'b1;
          // r_base has its offset bits cleared, so this never leaves the line.
          MEM_ADDRESS = r_base + WADDR_W'(w_issue_beat);
        end
      end
      S_RESPOND: begin
        DATA_FROM_L2_VALID_INS = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_instruction_responder.sv
module tb_l2_instruction_responder;

  localparam int AW    = 32;
  localparam int LW    = 512;
  localparam int WW    = 32;
  localparam int BEATS = 16;

  logic          CLK    = 1'b0;
  logic          RST_N  = 1'b0;
  logic          AVALID = 1'b0;
  logic          AREADY;
  logic [AW-3:0] AADDR  = '0;
  logic          DVALID;
  logic          DREADY = 1'b0;
  logic [LW-1:0] DDATA;
  logic          MEM_READ_EN;
  logic [AW-3:0] MEM_ADDRESS;
  logic [WW-1:0] MEM_DATA = '0;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  logic [AW-3:0] exp_addrs [$];
  logic [LW-1:0] exp_lines [$];
  logic [AW-3:0] obs_addr  [$];
  logic [LW-1:0] obs_line  [$];
  int            obs_rise  [$];
  int            obs_hs    [$];
  int rd_addr = 0;
  int rd_line = 0;
  int rd_rise = 0;
  int rd_hs   = 0;
  bit   mon_on     = 1'b0;
  logic prev_valid = 1'b0;

  l2_instruction_responder dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .ADDRESS_TO_L2_VALID_INS (AVALID),
    .ADDRESS_TO_L2_READY_INS (AREADY),
    .ADDRESS_TO_L2_INS       (AADDR),
    .DATA_FROM_L2_VALID_INS  (DVALID),
    .DATA_FROM_L2_READY_INS  (DREADY),
    .DATA_FROM_L2_INS        (DDATA),
    .MEM_READ_EN             (MEM_READ_EN),
    .MEM_ADDRESS             (MEM_ADDRESS),
    .MEM_DATA                (MEM_DATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Synchronous RAM model: word = its own address; junk when not read.
  always @(posedge CLK) MEM_DATA <= MEM_READ_EN ? {2'b00, MEM_ADDRESS} : 32'hDEADBEEF;

  // Observation recorder (sampled on the falling edge).
  always @(negedge CLK) begin
    if (mon_on) begin
      if (MEM_READ_EN) obs_addr.push_back(MEM_ADDRESS);
      if (DVALID && !prev_valid) obs_rise.push_back(edge_cnt);
      if (DVALID && DREADY) begin
        obs_line.push_back(DDATA);
        obs_hs.push_back(edge_cnt + 1);
      end
    end
    prev_valid = DVALID;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: expected fetch order and assembled line for a request.
  function automatic void push_expected(input logic [AW-3:0] a);
    logic [AW-3:0] base;
    logic [3:0]    off;
    logic [3:0]    idx;
    logic [LW-1:0] line;
    base = a & ~30'hF;
`ifdef L2_INS_CRITICAL_WORD_FIRST_EN
    off = a[3:0];
`else
    off = 4'd0;
`endif
    line = '0;
    for (int k = 0; k < BEATS; k++) begin
      line[k*WW +: WW] = {2'b00, base + 30'(k)};
      idx = off + 4'(k);
      exp_addrs.push_back(base + 30'(idx));
    end
    exp_lines.push_back(line);
  endfunction

  task automatic send_req(input logic [AW-3:0] a, input int budget,
                          output int acc, output bit ok);
    int n;
    n   = 0;
    ok  = 1'b0;
    acc = -1;
    AVALID = 1'b1;
    AADDR  = a;
    while (!AREADY && n < budget) begin
      step();
      n++;
    end
    if (AREADY) begin
      acc = edge_cnt + 1;
      ok  = 1'b1;
      push_expected(a);
    end
    step();
    AVALID = 1'b0;
  endtask

  task automatic wait_lines(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (obs_line.size() < rd_line + n && c < budget) begin
      step();
      c++;
    end
    ok = (obs_line.size() >= rd_line + n);
  endtask

  task automatic sync_obs();
    rd_addr = obs_addr.size();
    rd_line = obs_line.size();
    rd_rise = obs_rise.size();
    rd_hs   = obs_hs.size();
    exp_addrs.delete();
    exp_lines.delete();
  endtask

  task automatic test_reset();
    RST_N  = 1'b0;
    AVALID = 1'b0;
    DREADY = 1'b0;
    repeat (3) step();
    RST_N = 1'b1;
    total++; if (AREADY !== 1'b1)      begin bad++; $display("FAIL reset_ready: got %b want 1", AREADY); end
    total++; if (DVALID !== 1'b0)      begin bad++; $display("FAIL reset_valid: got %b want 0", DVALID); end
    total++; if (MEM_READ_EN !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", MEM_READ_EN); end
    total++; if (MEM_ADDRESS !== '0)   begin bad++; $display("FAIL reset_mem_addr: got %h want 0", MEM_ADDRESS); end
    total++; if (DDATA !== '0)         begin bad++; $display("FAIL reset_data: got %h want 0", DDATA); end
    mon_on = 1'b1;
    sync_obs();
  endtask

  task automatic test_single_fetch(input logic [AW-3:0] a, input string nm);
    int acc;
    bit ok;
    logic [AW-3:0] ea;
    logic [LW-1:0] el;
    sync_obs();
    DREADY = 1'b1;
    send_req(a, 20, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_accept: got not accepted want accepted", nm); end
    wait_lines(1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_timeout: got no line want 1 line", nm); end
    repeat (3) step();
    total++;
    if (obs_rise.size() <= rd_rise) begin
      bad++; $display("FAIL %s_latency: got no valid want %0d edges", nm, 18);
    end else if (obs_rise[rd_rise] - acc != 18) begin
      bad++; $display("FAIL %s_latency: got %0d edges want 18", nm, obs_rise[rd_rise] - acc);
    end
    total++;
    if (obs_addr.size() - rd_addr != exp_addrs.size()) begin
      bad++; $display("FAIL %s_addr_count: got %0d want %0d", nm, obs_addr.size() - rd_addr, exp_addrs.size());
    end
    for (int i = 0; exp_addrs.size() > 0 && rd_addr < obs_addr.size(); i++) begin
      ea = exp_addrs.pop_front();
      total++;
      if (obs_addr[rd_addr] !== ea) begin
        bad++; $display("FAIL %s_addr[%0d]: got %h want %h", nm, i, obs_addr[rd_addr], ea);
      end
      rd_addr++;
    end
    while (exp_lines.size() > 0 && rd_line < obs_line.size()) begin
      el = exp_lines.pop_front();
      total++;
      if (obs_line[rd_line] !== el) begin
        bad++; $display("FAIL %s_line: got %h want %h", nm, obs_line[rd_line], el);
      end
      rd_line++;
    end
    sync_obs();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    bit ok1, ok2, ok;
    logic [AW-3:0] ea;
    logic [LW-1:0] el;
    sync_obs();
    DREADY = 1'b1;
    send_req(30'h100, 20, acc1, ok1);
    send_req(30'h200, 20, acc2, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_accept: got %b%b want 11", ok1, ok2); end
    wait_lines(2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d lines want 2", obs_line.size() - rd_line); end
    repeat (3) step();
    total++;
    if (obs_rise.size() < rd_rise + 2 || obs_hs.size() < rd_hs + 1) begin
      bad++; $display("FAIL b2b_gap: got too few events want 2 valid rises");
    end else if (obs_rise[rd_rise + 1] - obs_hs[rd_hs] != 17) begin
      bad++; $display("FAIL b2b_gap: got %0d edges want 17", obs_rise[rd_rise + 1] - obs_hs[rd_hs]);
    end
    total++;
    if (obs_addr.size() - rd_addr != exp_addrs.size()) begin
      bad++; $display("FAIL b2b_addr_count: got %0d want %0d", obs_addr.size() - rd_addr, exp_addrs.size());
    end
    for (int i = 0; exp_addrs.size() > 0 && rd_addr < obs_addr.size(); i++) begin
      ea = exp_addrs.pop_front();
      total++;
      if (obs_addr[rd_addr] !== ea) begin
        bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, obs_addr[rd_addr], ea);
      end
      rd_addr++;
    end
    for (int i = 0; exp_lines.size() > 0 && rd_line < obs_line.size(); i++) begin
      el = exp_lines.pop_front();
      total++;
      if (obs_line[rd_line] !== el) begin
        bad++; $display("FAIL b2b_line[%0d]: got %h want %h", i, obs_line[rd_line], el);
      end
      rd_line++;
    end
    sync_obs();
  endtask

  task automatic test_backpressure();
    int acc1, acc2, acc3, acc4, hs_first;
    bit ok1, ok2, ok3, ok4, ok;
    logic [LW-1:0] held;
    logic [AW-3:0] ea;
    logic [LW-1:0] el;
    sync_obs();
    DREADY   = 1'b0;
    hs_first = -1;
    send_req(30'h00, 20, acc1, ok1);
    send_req(30'h10, 20, acc2, ok2);
    send_req(30'h20, 20, acc3, ok3);
    total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL bp_accept3: got %b%b%b want 111", ok1, ok2, ok3); end
    fork
      begin
        send_req(30'h30, 200, acc4, ok4);
      end
      begin
        int c;
        c = 0;
        while (!DVALID && c < 60) begin
          step();
          c++;
        end
        held = DDATA;
        repeat (4) step();
        total++; if (AREADY !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", AREADY); end
        total++; if (DVALID !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1", DVALID); end
        total++; if (DDATA !== held)  begin bad++; $display("FAIL bp_hold_data: got %h want %h", DDATA, held); end
        DREADY = 1'b1;
      end
    join
    total++; if (!ok4) begin bad++; $display("FAIL bp_accept4: got not accepted want accepted"); end
    wait_lines(4, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got %0d lines want 4", obs_line.size() - rd_line); end
    repeat (3) step();
    if (obs_hs.size() > rd_hs) hs_first = obs_hs[rd_hs];
    total++; if (acc4 != hs_first + 1) begin bad++; $display("FAIL bp_accept4_edge: got %0d want %0d", acc4, hs_first + 1); end
    total++;
    if (obs_addr.size() - rd_addr != exp_addrs.size()) begin
      bad++; $display("FAIL bp_addr_count: got %0d want %0d", obs_addr.size() - rd_addr, exp_addrs.size());
    end
    for (int i = 0; exp_addrs.size() > 0 && rd_addr < obs_addr.size(); i++) begin
      ea = exp_addrs.pop_front();
      total++;
      if (obs_addr[rd_addr] !== ea) begin
        bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, obs_addr[rd_addr], ea);
      end
      rd_addr++;
    end
    for (int i = 0; exp_lines.size() > 0 && rd_line < obs_line.size(); i++) begin
      el = exp_lines.pop_front();
      total++;
      if (obs_line[rd_line] !== el) begin
        bad++; $display("FAIL bp_line[%0d]: got %h want %h", i, obs_line[rd_line], el);
      end
      rd_line++;
    end
    sync_obs();
  endtask

  task automatic test_reset_mid_fetch();
    int acc;
    bit ok;
    sync_obs();
    DREADY = 1'b1;
    send_req(30'h300, 20, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_accept: got not accepted want accepted"); end
    repeat (5) step();
    // Now in the cycle of fetch beat 5.
    total++; if (MEM_READ_EN !== 1'b1) begin bad++; $display("FAIL rstmid_beat5_rd_en: got %b want 1", MEM_READ_EN); end
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    total++; if (obs_addr.size() - rd_addr != 5) begin bad++; $display("FAIL rstmid_issued: got %0d want 5", obs_addr.size() - rd_addr); end
    total++; if (DVALID !== 1'b0)      begin bad++; $display("FAIL rstmid_valid: got %b want 0", DVALID); end
    total++; if (MEM_READ_EN !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en: got %b want 0", MEM_READ_EN); end
    total++; if (AREADY !== 1'b1)      begin bad++; $display("FAIL rstmid_ready: got %b want 1", AREADY); end
    sync_obs();
    step();
    test_single_fetch(30'h40, "rstmid_refetch");
  endtask

  initial begin
    test_reset();
    test_single_fetch(30'h13, "single");
    test_back_to_back();
    test_backpressure();
    test_reset_mid_fetch();
    test_single_fetch(30'h3FFFFFF5, "wrap");
    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
